// File: rtl/sha256_id_arb_pkg.sv
// Shared types and constants for the ID-stream arbiter.
//   arb_state_e : arbiter FSM state (idle/arbitrating vs. locked onto one requester)
//   DefaultIdW  : default ID width, matches the ID buffer
package sha256_id_arb_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StLocked
   } arb_state_e;

   localparam int unsigned DefaultIdW = 6;

endpackage

// File: rtl/sha256_rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at rr_ptr and wrapping modulo NUM_REQ; returns the first set index.
//   req    in  NUM_REQ  request vector
//   rr_ptr in  PTR_W    index with highest priority (must be < NUM_REQ)
//   idx    out PTR_W    selected index (0 when nothing requested)
//   any    out 1        at least one request present
module sha256_rr_pick #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [PTR_W-1:0]   idx,
   output logic               any
);

   int unsigned cand;

   always_comb begin
      idx  = '0;
      any  = 1'b0;
      cand = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = (32'(rr_ptr) + k) % NUM_REQ;
         if (!any && req[cand]) begin
            any = 1'b1;
            idx = PTR_W'(cand);
         end
      end
   end

endmodule

// File: rtl/sha256_id_arbiter.sv
// Packet-level round-robin arbiter sharing the ID-buffer input stream between NUM_REQ requesters.
// A requester is granted after a one-cycle arbitration bubble and keeps the grant until its
// last beat handshakes; beats pass through combinationally with no storage.
//   clk, nrst      clock, synchronous active-low reset
//   en             low freezes the arbiter (no grants, no transfers)
//   sync_rst       synchronous soft reset, active-high, same effect as nrst
//   req_*          per-requester ID stream (id/last/valid in, ready out)
//   id_out_*       stream towards the ID buffer
//   status_grant   current / last granted requester
//   status_busy    high while locked onto a requester
//   status_pkt_cnt completed packets, wrapping
module sha256_id_arbiter
   import sha256_id_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ID_W    = DefaultIdW,
   parameter int unsigned CNT_W   = 16,
   localparam int unsigned GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic                    en,
   input  logic                    sync_rst,
   input  logic [NUM_REQ*ID_W-1:0] req_id,
   input  logic [NUM_REQ-1:0]      req_last,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [ID_W-1:0]         id_out,
   output logic                    id_out_last,
   output logic                    id_out_valid,
   input  logic                    id_out_ready,
   output logic [GRANT_W-1:0]      status_grant,
   output logic                    status_busy,
   output logic [CNT_W-1:0]        status_pkt_cnt
);

   arb_state_e         state_q, state_d;
   logic [GRANT_W-1:0] grant_q, grant_d;
   logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

   logic [GRANT_W-1:0] pick_idx;
   logic               pick_any;

   sha256_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (GRANT_W)
   ) u_pick (
      .req    (req_valid),
      .rr_ptr (rr_ptr_q),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_ff @(posedge clk) begin
      if (!nrst || sync_rst) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         pkt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      rr_ptr_d     = rr_ptr_q;
      pkt_cnt_d    = pkt_cnt_q;
      req_ready    = '0;
      id_out       = '0;
      id_out_last  = 1'b0;
      id_out_valid = 1'b0;

      // With en low everything holds and no handshake can occur.
      if (en) begin
         case (state_q)
            StIdle: begin
               if (pick_any) begin
                  grant_d = pick_idx;
                  state_d = StLocked;
               end
            end
            StLocked: begin
               id_out             = req_id[grant_q*ID_W +: ID_W];
               id_out_last        = req_last[grant_q];
               id_out_valid       = req_valid[grant_q];
               // Ready is independent of req_valid: no valid->ready loop.
               req_ready[grant_q] = id_out_ready;
               if (id_out_valid && id_out_ready && id_out_last) begin
                  pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                  rr_ptr_d  = (grant_q == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_q + GRANT_W'(1);
                  state_d   = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign status_grant   = grant_q;
   assign status_busy    = (state_q == StLocked);
   assign status_pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_sha256_id_arbiter.sv
// Scoreboard bench for sha256_id_arbiter (NUM_REQ=2, ID_W=6). A second instance with CNT_W=2
// shares all inputs to exercise packet-counter wrap.
module tb_sha256_id_arbiter;

   typedef struct packed {
      logic [5:0] id;
      logic       last;
   } beat_t;

   typedef struct packed {
      logic [5:0] id;
      logic       last;
      logic       grant;
   } exp_t;

   logic        clk;
   logic        nrst;
   logic        en;
   logic        sync_rst;
   logic [11:0] req_id;
   logic [1:0]  req_last;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [5:0]  id_out;
   logic        id_out_last;
   logic        id_out_valid;
   logic        id_out_ready;
   logic [0:0]  status_grant;
   logic        status_busy;
   logic [15:0] status_pkt_cnt;

   logic [1:0]  w_req_ready;
   logic [5:0]  w_id_out;
   logic        w_id_out_last;
   logic        w_id_out_valid;
   logic [0:0]  w_status_grant;
   logic        w_status_busy;
   logic [1:0]  w_status_pkt_cnt;

   beat_t src0_q[$];
   beat_t src1_q[$];
   exp_t  exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   sha256_id_arbiter #(
      .NUM_REQ (2),
      .ID_W    (6),
      .CNT_W   (16)
   ) dut (
      .clk            (clk),
      .nrst           (nrst),
      .en             (en),
      .sync_rst       (sync_rst),
      .req_id         (req_id),
      .req_last       (req_last),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .id_out         (id_out),
      .id_out_last    (id_out_last),
      .id_out_valid   (id_out_valid),
      .id_out_ready   (id_out_ready),
      .status_grant   (status_grant),
      .status_busy    (status_busy),
      .status_pkt_cnt (status_pkt_cnt)
   );

   sha256_id_arbiter #(
      .NUM_REQ (2),
      .ID_W    (6),
      .CNT_W   (2)
   ) dut_w (
      .clk            (clk),
      .nrst           (nrst),
      .en             (en),
      .sync_rst       (sync_rst),
      .req_id         (req_id),
      .req_last       (req_last),
      .req_valid      (req_valid),
      .req_ready      (w_req_ready),
      .id_out         (w_id_out),
      .id_out_last    (w_id_out_last),
      .id_out_valid   (w_id_out_valid),
      .id_out_ready   (id_out_ready),
      .status_grant   (w_status_grant),
      .status_busy    (w_status_busy),
      .status_pkt_cnt (w_status_pkt_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Main process writes only here: 2 units after a rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input int r, input logic [5:0] id, input logic last);
      beat_t b;
      b.id   = id;
      b.last = last;
      if (r == 0) src0_q.push_back(b);
      else        src1_q.push_back(b);
   endtask

   task automatic expect_beat(input logic [5:0] id, input logic last, input logic grant);
      exp_t e;
      e.id    = id;
      e.last  = last;
      e.grant = grant;
      exp_q.push_back(e);
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while ((src0_q.size() != 0 || src1_q.size() != 0 || exp_q.size() != 0 || status_busy)
             && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) fail_now({name, "_timeout"});
   endtask

   task automatic wait_hs(input string name);
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(id_out_valid && id_out_ready) && t < 50);
      if (t >= 50) fail_now({name, "_hs_timeout"});
   endtask

   // Requester model: hold the head beat until it handshakes.
   initial begin
      logic [1:0] hs;
      req_valid = '0;
      req_id    = '0;
      req_last  = '0;
      forever begin
         @(negedge clk);
         hs = req_valid & req_ready;
         @(posedge clk);
         #1;
         if (hs[0] && src0_q.size() != 0) void'(src0_q.pop_front());
         if (hs[1] && src1_q.size() != 0) void'(src1_q.pop_front());
         req_valid[0] = (src0_q.size() != 0);
         req_id[5:0]  = (src0_q.size() != 0) ? src0_q[0].id : 6'd0;
         req_last[0]  = (src0_q.size() != 0) ? src0_q[0].last : 1'b0;
         req_valid[1] = (src1_q.size() != 0);
         req_id[11:6] = (src1_q.size() != 0) ? src1_q[0].id : 6'd0;
         req_last[1]  = (src1_q.size() != 0) ? src1_q[0].last : 1'b0;
      end
   end

   // Monitor: every accepted output beat must match the scoreboard head.
   initial begin
      exp_t e;
      bit   have_prev;
      bit   at_first;
      int   last_end;
      have_prev = 1'b0;
      at_first  = 1'b1;
      last_end  = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!nrst || sync_rst) begin
            have_prev = 1'b0;
            at_first  = 1'b1;
         end else if (id_out_valid && id_out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_beat: got id %0d, expected no beat", id_out);
            end else begin
               e = exp_q.pop_front();
               check("beat_id", 32'(id_out), 32'(e.id));
               check("beat_last", 32'(id_out_last), 32'(e.last));
               check("beat_grant", 32'(status_grant), 32'(e.grant));
               if (at_first && have_prev) check("bubble", 32'(cyc - last_end >= 2), 32'd1);
               at_first = id_out_last;
               if (id_out_last) begin
                  have_prev = 1'b1;
                  last_end  = cyc;
               end
            end
         end
      end
   end

   initial begin
      int t;
      logic [1:0] prev_cnt;
      logic [1:0] cnt_tbl [5];
      cnt_tbl[0] = 2'd1;
      cnt_tbl[1] = 2'd2;
      cnt_tbl[2] = 2'd3;
      cnt_tbl[3] = 2'd0;
      cnt_tbl[4] = 2'd1;

      nrst         = 1'b0;
      en           = 1'b1;
      sync_rst     = 1'b0;
      id_out_ready = 1'b1;
      repeat (3) tick();

      // Reset state
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_valid", 32'(id_out_valid), 32'd0);
      check("rst_id_out", 32'(id_out), 32'd0);
      check("rst_last", 32'(id_out_last), 32'd0);
      check("rst_busy", 32'(status_busy), 32'd0);
      check("rst_grant", 32'(status_grant), 32'd0);
      check("rst_cnt", 32'(status_pkt_cnt), 32'd0);
      tick();
      nrst = 1'b1;
      tick();

      // 1: single requester, 3-beat packet, one bubble before first beat
      send(0, 6'd5, 1'b0);
      send(0, 6'd6, 1'b0);
      send(0, 6'd7, 1'b1);
      expect_beat(6'd5, 1'b0, 1'b0);
      expect_beat(6'd6, 1'b0, 1'b0);
      expect_beat(6'd7, 1'b1, 1'b0);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!req_valid[0] && t < 20);
      check("t1_bubble_busy", 32'(status_busy), 32'd0);
      check("t1_bubble_valid", 32'(id_out_valid), 32'd0);
      @(negedge clk);
      check("t1_first_busy", 32'(status_busy), 32'd1);
      check("t1_first_id", 32'(id_out), 32'd5);
      check("t1_first_ready", 32'(req_ready), 32'b01);
      drain("t1");
      check("t1_cnt", 32'(status_pkt_cnt), 32'd1);
      check("t1_cnt_w", 32'(w_status_pkt_cnt), 32'd1);

      // 2: both valid out of reset, 2-beat packets
      tick();
      nrst = 1'b0;
      send(0, 6'd1, 1'b0);
      send(0, 6'd2, 1'b1);
      send(1, 6'd10, 1'b0);
      send(1, 6'd11, 1'b1);
      expect_beat(6'd1, 1'b0, 1'b0);
      expect_beat(6'd2, 1'b1, 1'b0);
      expect_beat(6'd10, 1'b0, 1'b1);
      expect_beat(6'd11, 1'b1, 1'b1);
      tick();
      tick();
      nrst = 1'b1;
      drain("t2");
      check("t2_grant", 32'(status_grant), 32'd1);
      check("t2_cnt", 32'(status_pkt_cnt), 32'd2);

      // 3: both continuously valid, single-beat packets, strict alternation
      tick();
      for (int k = 0; k < 4; k++) begin
         send(0, 6'(32 + k), 1'b1);
         send(1, 6'(48 + k), 1'b1);
         expect_beat(6'(32 + k), 1'b1, 1'b0);
         expect_beat(6'(48 + k), 1'b1, 1'b1);
      end
      drain("t3");
      check("t3_cnt", 32'(status_pkt_cnt), 32'd10);
      check("t3_cnt_w", 32'(w_status_pkt_cnt), 32'd2);

      // 4: back-pressure and enable stall mid-packet
      tick();
      for (int k = 0; k < 4; k++) begin
         send(0, 6'(20 + k), (k == 3));
         expect_beat(6'(20 + k), (k == 3), 1'b0);
      end
      wait_hs("t4");
      tick();
      id_out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("t4_bp_ready", 32'(req_ready), 32'd0);
         check("t4_bp_busy", 32'(status_busy), 32'd1);
      end
      tick();
      id_out_ready = 1'b1;
      en           = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("t4_en_ready", 32'(req_ready), 32'd0);
         check("t4_en_valid", 32'(id_out_valid), 32'd0);
         check("t4_en_busy", 32'(status_busy), 32'd1);
      end
      tick();
      en = 1'b1;
      drain("t4");
      check("t4_cnt", 32'(status_pkt_cnt), 32'd11);

      // 5: soft reset while locked after first of three beats
      tick();
      send(0, 6'd40, 1'b0);
      send(0, 6'd41, 1'b0);
      send(0, 6'd42, 1'b1);
      expect_beat(6'd40, 1'b0, 1'b0);
      wait_hs("t5");
      tick();
      sync_rst     = 1'b1;
      id_out_ready = 1'b0;
      src0_q.delete();
      tick();
      sync_rst     = 1'b0;
      id_out_ready = 1'b1;
      @(negedge clk);
      check("t5_busy", 32'(status_busy), 32'd0);
      check("t5_cnt", 32'(status_pkt_cnt), 32'd0);
      check("t5_cnt_w", 32'(w_status_pkt_cnt), 32'd0);
      check("t5_ready", 32'(req_ready), 32'd0);
      check("t5_valid", 32'(id_out_valid), 32'd0);
      check("t5_grant", 32'(status_grant), 32'd0);
      tick();
      send(0, 6'd50, 1'b1);
      send(1, 6'd51, 1'b1);
      expect_beat(6'd50, 1'b1, 1'b0);
      expect_beat(6'd51, 1'b1, 1'b1);
      drain("t5b");
      check("t5b_cnt", 32'(status_pkt_cnt), 32'd2);

      // 6: 2-bit counter wraps
      tick();
      nrst = 1'b0;
      tick();
      nrst = 1'b1;
      tick();
      for (int p = 0; p < 5; p++) begin
         prev_cnt = w_status_pkt_cnt;
         send(1, 6'(60 + p), 1'b1);
         expect_beat(6'(60 + p), 1'b1, 1'b1);
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (w_status_pkt_cnt == prev_cnt && t < 30);
         check("t6_cnt_w", 32'(w_status_pkt_cnt), 32'(cnt_tbl[p]));
         tick();
      end
      drain("t6");
      check("t6_cnt", 32'(status_pkt_cnt), 32'd5);
      check("leftover_exp", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
